// File: rtl/pe_mac_tile.sv
// Per-lane multiply-accumulate tile with command/result handshakes and reduction mode.
// Optional clamping accumulation is enabled by defining PE_SAT_EN.
module pe_mac_tile #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int RES_W   = 32,
  parameter int SHARE_N = 4,
  parameter int LEN_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_mode,
  input  logic [LEN_W-1:0]                   cmd_len,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0]     cmd_psel,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [((SHARE_N > 1) ? $clog2(SHARE_N) : 1)-1:0] in_mux,
  input  logic                               in_mask,
  input  logic [SHARE_N*LANES*DATA_W-1:0]    share_data_in,
  input  logic [LANES*DATA_W-1:0]            param_in,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [LANES*RES_W-1:0]             res_data,
  output logic                               busy,
  output logic                               err,
  output logic                               sat
);
  localparam int PSEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t state_reg, state_next;

  logic [1:0]           mode_reg;
  logic [LEN_W-1:0]     len_reg;
  logic [PSEL_W-1:0]    psel_reg;
  logic [LEN_W-1:0]     beat_cnt_reg;
  logic [1:0]           drain_cnt_reg;
  logic                 err_reg;
  logic                 v1_reg, v2_reg;
  logic [LANES*RES_W-1:0] res_data_reg;
  logic [LANES*RES_W-1:0] res_load;

  logic signed [RES_W-1:0] prod_ext [LANES];
  logic signed [RES_W-1:0] acc_view [LANES];
  logic signed [RES_W-1:0] red_sum;
  logic [LANES-1:0]        clamp;

  logic cmd_fire, beat_fire, res_fire, last_beat, drain_done;

  assign cmd_fire   = cmd_valid && (state_reg == S_IDLE);
  assign beat_fire  = in_valid && (state_reg == S_RUN);
  assign res_fire   = res_ready && (state_reg == S_OUT);
  assign last_beat  = beat_fire && (beat_cnt_reg == len_reg - LEN_W'(1));
  assign drain_done = (state_reg == S_DRAIN) && (drain_cnt_reg == 2'd2);

  assign cmd_ready = (state_reg == S_IDLE);
  assign in_ready  = (state_reg == S_RUN);
  assign res_valid = (state_reg == S_OUT);
  assign busy      = (state_reg != S_IDLE);
  assign err       = err_reg;
  assign res_data  = res_data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // DRAIN spans the product and accumulate stages plus the result register load.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (cmd_fire) state_next = (cmd_len == '0) ? S_OUT : S_RUN;
      S_RUN:   if (last_beat) state_next = S_DRAIN;
      S_DRAIN: if (drain_done) state_next = S_OUT;
      S_OUT:   if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg      <= '0;
      len_reg       <= '0;
      psel_reg      <= '0;
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      err_reg       <= 1'b0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      v1_reg <= beat_fire;
      v2_reg <= v1_reg;
      if (cmd_fire) begin
        mode_reg     <= cmd_mode;
        len_reg      <= cmd_len;
        psel_reg     <= cmd_psel;
        err_reg      <= (cmd_mode == 2'b11);
        beat_cnt_reg <= '0;
      end else if (beat_fire) begin
        beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
      end
      drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + 2'd1 : 2'd0;
      if (cmd_fire || res_fire) res_data_reg <= '0;
      else if (drain_done)      res_data_reg <= res_load;
    end
  end

  // Reduction sum is deliberately formed at RES_W and may wrap before accumulation.
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < LANES; i++) red_sum = red_sum + prod_ext[i];
  end

`ifdef PE_SAT_EN
  function automatic logic [RES_W:0] sat_add(input logic [RES_W-1:0] x, input logic [RES_W-1:0] y);
    logic [RES_W:0] s;
    s = {x[RES_W-1], x} + {y[RES_W-1], y};
    if (s[RES_W] != s[RES_W-1])
      return s[RES_W] ? {2'b11, {(RES_W-1){1'b0}}} : {2'b10, {(RES_W-1){1'b1}}};
    return {1'b0, s[RES_W-1:0]};
  endfunction

  logic sat_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sat_reg <= 1'b0;
    else if (cmd_fire)        sat_reg <= 1'b0;
    else if (v2_reg && |clamp) sat_reg <= 1'b1;
  end
  assign sat = sat_reg;
`else
  assign sat = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] a_sel, p_sel, a_reg, p_reg;
      logic signed [PROD_W-1:0] prod_reg;
      logic signed [RES_W-1:0]  addend, acc_next, acc_reg;

      always_comb begin
        a_sel = '0;
        if (in_mask && (int'(in_mux) < SHARE_N))
          a_sel = share_data_in[(int'(in_mux) * LANES + gi) * DATA_W +: DATA_W];
        p_sel = (mode_reg == 2'b01) ? param_in[int'(psel_reg) * DATA_W +: DATA_W]
                                    : param_in[gi * DATA_W +: DATA_W];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_reg    <= '0;
          p_reg    <= '0;
          prod_reg <= '0;
        end else begin
          if (beat_fire) begin
            a_reg <= a_sel;
            p_reg <= p_sel;
          end
          if (v1_reg) prod_reg <= PROD_W'(a_reg) * PROD_W'(p_reg);
        end
      end

      assign prod_ext[gi] = RES_W'(prod_reg);
      assign addend = (mode_reg == 2'b10) ? ((gi == 0) ? red_sum : '0) : prod_ext[gi];

`ifdef PE_SAT_EN
      logic [RES_W:0] sum_sat;
      assign sum_sat   = sat_add(acc_reg, addend);
      assign acc_next  = sum_sat[RES_W-1:0];
      assign clamp[gi] = sum_sat[RES_W];
`else
      assign acc_next  = acc_reg + addend;
      assign clamp[gi] = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          acc_reg <= '0;
        else if (cmd_fire) acc_reg <= '0;
        else if (v2_reg)   acc_reg <= acc_next;
      end

      assign acc_view[gi] = acc_reg;
      assign res_load[gi*RES_W +: RES_W] = (mode_reg == 2'b10) ? acc_view[0] : acc_reg;
    end
  endgenerate

endmodule
